mips_instr_encoder: RTL and testbench

- Streaming MIPS instruction encoder: the inverse of the control/opcode decoder.
- Accepts symbolic instruction fields (class code, register numbers, shamt, funct, immediate, jump target) over a valid/ready handshake.
- Emits 32-bit machine words, each tagged with its instruction-memory byte address, through a 2-entry output buffer.
- Used by the program loader and by self-checking benches to fill instruction memory with opcodes the control decoder understands.

---
 rtl/mips_instr_encoder.sv | 145 ++++++++++++++
 tb/tb_mips_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns symbolic MIPS instruction fields into 32-bit machine
// words. Each word is tagged with its instruction-memory byte address and queued
// in a 2-entry output buffer.
// Optional build macro INSTR_ENC_STRICT_EN: rejects JR encodings with stray
// rt/rd/shamt bits and R-type words whose funct is JR (001000). When it is not
// defined, JR zeroes those fields and R-type passes funct through unchanged.
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  entry_t      slot0_q, slot0_d;   // head of the buffer
  entry_t      slot1_q, slot1_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [5:0]  i_opcode;
  logic [31:0] enc_instr;
  logic        enc_legal;
  logic        accept, push, pop;

  // I-type opcode lookup for classes 4..13
  always_comb begin
    i_opcode = 6'b000000;
    case (in_class)
      4'd4:    i_opcode = 6'b000100;
      4'd5:    i_opcode = 6'b000101;
      4'd6:    i_opcode = 6'b001000;
      4'd7:    i_opcode = 6'b001001;
      4'd8:    i_opcode = 6'b001010;
      4'd9:    i_opcode = 6'b001011;
      4'd10:   i_opcode = 6'b001100;
      4'd11:   i_opcode = 6'b001101;
      4'd12:   i_opcode = 6'b100011;
      4'd13:   i_opcode = 6'b101011;
      default: i_opcode = 6'b000000;
    endcase
  end

  // Build the machine word and decide whether the input is legal
  always_comb begin
    enc_instr = 32'h0000_0000;
    enc_legal = 1'b1;
    case (in_class)
      4'd0: begin
        enc_instr = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
`ifdef INSTR_ENC_STRICT_EN
        if (in_funct == FUNCT_JR) enc_legal = 1'b0;
`endif
      end
      4'd1: begin
        enc_instr = {6'b000000, in_rs, 15'b0, FUNCT_JR};
`ifdef INSTR_ENC_STRICT_EN
        if ((in_rt != 5'd0) || (in_rd != 5'd0) || (in_shamt != 5'd0)) enc_legal = 1'b0;
`endif
      end
      4'd2:  enc_instr = {6'b000010, in_target};
      4'd3:  enc_instr = {6'b000011, in_target};
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13:
        enc_instr = {i_opcode, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // in_ready looks only at registered occupancy (and rst), never at out_ready
  assign in_ready  = !rst && (occ_q < 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_instr = slot0_q.instr;
  assign out_addr  = slot0_q.addr;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal;
  assign pop    = out_valid && out_ready;

  // Buffer, address and error-count next state. The pop is applied first so
  // that the push lands in the slot that is free afterwards.
  always_comb begin
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    occ_d       = occ_q;
    next_addr_d = next_addr_q;
    err_d       = accept && !enc_legal;
    err_cnt_d   = err_cnt_q;
    if (pop) begin
      slot0_d = slot1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) slot0_d = '{instr: enc_instr, addr: next_addr_q};
      else               slot1_d = '{instr: enc_instr, addr: next_addr_q};
      occ_d       = occ_d + 2'd1;
      next_addr_d = next_addr_q + 32'd4;
    end
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // State registers with synchronous reset; reset drops any buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q     <= '0;
      slot1_q     <= '0;
      occ_q       <= 2'd0;
      next_addr_q <= BASE_ADDR;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      occ_q       <= occ_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_mips_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;   // close to the top to exercise wrap
`ifdef INSTR_ENC_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_class = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_cnt;

  mips_instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the instruction-set rules; returns legality.
  function automatic bit ref_enc(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] imm, input logic [25:0] tg,
                                 output logic [31:0] w);
    int op;
    w = 32'h0;
    if (c == 0) begin
      w = {6'd0, rs, rt, rd, sh, fn};
      return !(STRICT && fn == 6'd8);
    end
    if (c == 1) begin
      w = {6'd0, rs, 21'd8};
      return !(STRICT && (rt != 0 || rd != 0 || sh != 0));
    end
    if (c == 2 || c == 3) begin
      w = {6'(c), tg};
      return 1'b1;
    end
    if (c >= 4 && c <= 13) begin
      if (c <= 5)       op = int'(c);           // BEQ 4, BNE 5
      else if (c <= 11) op = int'(c) + 2;       // ADDI..ORI are 8..13
      else if (c == 12) op = 35;                // LW
      else              op = 43;                // SW
      w = {6'(op), rs, rt, imm};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  typedef struct { logic [31:0] instr; logic [31:0] addr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_na = BASE;
  bit          m_err = 1'b0;
  int          m_cnt = 0;
  bit          mon_en = 1'b0;
  bit          m_acc, m_pop, m_lg;
  logic [31:0] m_w;

  // Behavioural model: a queue of at most two words
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_na = BASE; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_pop = (mq.size() > 0) && out_ready;
      m_lg  = ref_enc(in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, m_w);
      if (m_pop) void'(mq.pop_front());
      m_err = m_acc && !m_lg;
      if (m_acc && m_lg) begin
        mq.push_back('{m_w, m_na});
        m_na = m_na + 32'd4;
      end
      if (m_err && m_cnt < 255) m_cnt++;
    end
  end

  // Compare DUT against the model shortly after every rising edge
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      chk("mon_in_ready", 32'(in_ready), 32'(!rst && mq.size() < 2));
      chk("mon_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("mon_err", 32'(err), 32'(m_err));
      chk("mon_err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (mq.size() != 0) begin
        chk("mon_out_instr", out_instr, mq[0].instr);
        chk("mon_out_addr", out_addr, mq[0].addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tg);
    in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg; in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tg;
    bit          legal;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[10];
  int   n_legal;
  int   exp_cnt;

  initial begin
    tbl[0] = '{4'd0,  5'd1,  5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0,       1'b1,    32'h0022_1820};
    tbl[1] = '{4'd6,  5'd0,  5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0,       1'b1,    32'h2008_0005};
    tbl[2] = '{4'd12, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0,       1'b1,    32'h8FA8_0004};
    tbl[3] = '{4'd4,  5'd1,  5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0,       1'b1,    32'h1022_FFFF};
    tbl[4] = '{4'd2,  5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0100000, 1'b1,    32'h0810_0000};
    tbl[5] = '{4'd1,  5'd31, 5'd5, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0,       !STRICT, 32'h03E0_0008};
    tbl[6] = '{4'd15, 5'd1,  5'd1, 5'd1, 5'd1, 6'h01, 16'h1234, 26'h0,       1'b0,    32'h0};
    tbl[7] = '{4'd13, 5'd2,  5'd3, 5'd0, 5'd0, 6'h00, 16'h0010, 26'h0,       1'b1,    32'hAC43_0010};
    tbl[8] = '{4'd0,  5'd1,  5'd0, 5'd0, 5'd0, 6'h08, 16'h0000, 26'h0,       !STRICT, 32'h0020_0008};
    tbl[9] = '{4'd11, 5'd4,  5'd5, 5'd0, 5'd0, 6'h00, 16'hABCD, 26'h0,       1'b1,    32'h3485_ABCD};

    // Reset state
    rst = 1'b1;
    step(); step();
    mon_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Vector table, one word at a time with the consumer ready
    out_ready = 1'b1;
    n_legal = 0;
    exp_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].cls, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].fn, tbl[i].imm, tbl[i].tg);
      step();
      in_valid = 1'b0;
      if (tbl[i].legal) begin
        chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].instr);
        chk($sformatf("vec%0d_addr", i), out_addr, BASE + 32'(4 * n_legal));
        chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
        n_legal++;
      end else begin
        exp_cnt++;
        chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd0);
        chk($sformatf("vec%0d_err", i), 32'(err), 32'd1);
        chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(exp_cnt));
      end
      step();
      chk($sformatf("vec%0d_err_clear", i), 32'(err), 32'd0);
    end
    chk("table_err_cnt", 32'(err_cnt), STRICT ? 32'd3 : 32'd1);

    // Backpressure: three words offered, only two taken
    do_reset();
    out_ready = 1'b0;
    drive(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    step();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    step();
    drive(4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000);
    step(); step();
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head_instr", out_instr, 32'h2008_0005);
    chk("bp_head_addr", out_addr, BASE);
    out_ready = 1'b1;
    step();
    chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_second_instr", out_instr, 32'h0022_1820);
    chk("bp_second_addr", out_addr, BASE + 32'd4);
    step();
    in_valid = 1'b0;
    chk("bp_third_instr", out_instr, 32'h0810_0000);
    chk("bp_third_addr", out_addr, BASE + 32'd8);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Illegal class and counter saturation
    do_reset();
    drive(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    chk("ill_err_pulse", 32'(err), 32'd1);
    chk("ill_err_cnt", 32'(err_cnt), 32'd1);
    step();
    chk("ill_err_clear", 32'(err), 32'd0);
    in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    step();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    drive(4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h8000, 26'h0);
    step();
    in_valid = 1'b0;
    chk("ill_addr_unchanged", out_addr, BASE);
    chk("ill_addiu_instr", out_instr, 32'h2464_8000);
    step();

    // Reset mid-stream with two entries buffered
    out_ready = 1'b0;
    drive(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0);
    step(); step();
    chk("mid_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    chk("mid_new_addr", out_addr, BASE);
    chk("mid_new_instr", out_instr, 32'h3022_00FF);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_class  = ($urandom_range(0, 5) == 0) ? 4'd1 : 4'($urandom);
      in_rs     = 5'($urandom);
      in_rt     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      in_rd     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      in_shamt  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      in_funct  = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
